// File: rtl/ps2_key_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard decoder: decoder state type,
// set-2 scancodes, held-key bit indices and small helper functions
// (parity check, scancode-to-key mapping).
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  // One held bit per physical key
  localparam int N_KEYS    = 7;
  localparam int KEY_A     = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_D     = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_W     = 4;
  localparam int KEY_SPACE = 5;
  localparam int KEY_UP    = 6;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic parity_odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // One-hot held-bit mask for a non-extended scancode (zero if unmapped)
  function automatic logic [N_KEYS-1:0] map_plain(input logic [7:0] code);
    logic [N_KEYS-1:0] mask;
    mask = 7'b000_0000;
    case (code)
      SC_A:     mask[KEY_A]     = 1'b1;
      SC_D:     mask[KEY_D]     = 1'b1;
      SC_W:     mask[KEY_W]     = 1'b1;
      SC_SPACE: mask[KEY_SPACE] = 1'b1;
      default:  mask = 7'b000_0000;
    endcase
    return mask;
  endfunction

  // One-hot held-bit mask for an E0-prefixed scancode (zero if unmapped)
  function automatic logic [N_KEYS-1:0] map_ext(input logic [7:0] code);
    logic [N_KEYS-1:0] mask;
    mask = 7'b000_0000;
    case (code)
      SC_LEFT:  mask[KEY_LEFT]  = 1'b1;
      SC_RIGHT: mask[KEY_RIGHT] = 1'b1;
      SC_UP:    mask[KEY_UP]    = 1'b1;
      default:  mask = 7'b000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 frame receiver: synchronises the raw pins, glitch-filters the PS/2
// clock, samples data on filtered falling edges, assembles an 11-bit frame
// and checks start/parity/stop. A stall mid-frame longer than the timeout
// aborts the frame.
// Ports:
//   clk          in  system clock
//   rst          in  reset, active-high (already synchronised on release)
//   i_ps2_clk    in  raw PS/2 clock pin
//   i_ps2_data   in  raw PS/2 data pin
//   o_rx_byte    out last received data byte
//   o_byte_valid out one-cycle pulse, o_rx_byte holds a good byte
//   o_frame_err  out one-cycle pulse on framing/parity/timeout error
// ---------------------------------------------------------------------------
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int FLT_W       = $clog2(FILTER_LEN + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_data_sync;
  logic             r_clk_filt;
  logic [FLT_W-1:0] r_filt_cnt;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_clk_s;
  logic             w_data_s;
  logic             w_fall;
  logic             w_frame_ok;

  assign w_clk_s  = r_clk_sync[1];
  assign w_data_s = r_data_sync[1];

  // The filtered level flips on this cycle, and it flips to 0: a falling edge
  assign w_fall = (w_clk_s != r_clk_filt) && (r_filt_cnt == FLT_LAST) && !w_clk_s;

  // r_shift holds start (bit 0), D0..D7 (bits 8:1) and parity (bit 9)
  assign w_frame_ok = !r_shift[0] && w_data_s && parity_odd_ok(r_shift[8:1], r_shift[9]);

  // Two-flop synchronisers for the asynchronous pins (idle-high reset value)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

  // Glitch filter: accept a new clock level after FILTER_LEN consecutive samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FLT_LAST) begin
      r_clk_filt <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FLT_ONE;
    end
  end

  // Frame assembly, end-of-frame checks and mid-frame timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= 10'd0;
      r_to_cnt     <= '0;
      o_rx_byte    <= 8'd0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          // Stop bit is being sampled now
          r_bit_cnt <= 4'd0;
          if (w_frame_ok) begin
            o_rx_byte    <= r_shift[8:1];
            o_byte_valid <= 1'b1;
          end else begin
            o_frame_err <= 1'b1;
          end
        end else begin
          r_shift   <= {w_data_s, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TO_LAST) begin
          // Stalled mid-frame: abandon it and wait for a fresh start bit
          r_bit_cnt   <= 4'd0;
          r_to_cnt    <= '0;
          o_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_ONE;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 set-2 make/break codes into level-held movement flags for the
// character controller.
// Ports:
//   clk          in  system clock (65 MHz pixel clock)
//   rst          in  reset, asynchronous assert, synchronous release
//   i_ps2_clk    in  raw PS/2 clock pin
//   i_ps2_data   in  raw PS/2 data pin
//   o_stepleft   out held while A or Left-arrow is down
//   o_stepright  out held while D or Right-arrow is down
//   o_stepjump   out held while W, Space or Up-arrow is down
//   o_frame_err  out one-cycle pulse on parity/start/stop/timeout error
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_stepleft,
  output logic o_stepright,
  output logic o_stepjump,
  output logic o_frame_err
);

  logic [1:0]        r_rst_pipe;
  logic              w_rst;
  logic [7:0]        w_rx_byte;
  logic              w_byte_valid;
  logic              w_frame_err;
  dec_state_t        r_state;
  dec_state_t        w_state_next;
  logic [N_KEYS-1:0] r_held;
  logic [N_KEYS-1:0] w_held_next;

  // Reset bridge: reset takes effect at once, its release waits two clock edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst = r_rst_pipe[1];

  ps2_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .clk         (clk),
    .rst         (w_rst),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_rx_byte   (w_rx_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  assign o_frame_err = w_frame_err;

  // Decoder state and held-key register
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_held  <= 7'b000_0000;
    end else begin
      r_state <= w_state_next;
      r_held  <= w_held_next;
    end
  end

  // Next-state and held-key update; only a good byte moves the decoder
  always_comb begin
    w_state_next = r_state;
    w_held_next  = r_held;
    if (w_frame_err) begin
      w_state_next = IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        IDLE: begin
          if (w_rx_byte == SC_EXT) begin
            w_state_next = EXT;
          end else if (w_rx_byte == SC_BRK) begin
            w_state_next = BRK;
          end else begin
            // Typematic repeats OR in an already-set bit: no change
            w_held_next  = r_held | map_plain(w_rx_byte);
            w_state_next = IDLE;
          end
        end
        EXT: begin
          if (w_rx_byte == SC_BRK) begin
            w_state_next = EXT_BRK;
          end else begin
            w_held_next  = r_held | map_ext(w_rx_byte);
            w_state_next = IDLE;
          end
        end
        BRK: begin
          w_held_next  = r_held & ~map_plain(w_rx_byte);
          w_state_next = IDLE;
        end
        EXT_BRK: begin
          w_held_next  = r_held & ~map_ext(w_rx_byte);
          w_state_next = IDLE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Registered movement flags, built from the next held value so they move
  // on the same edge as the held register
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      o_stepleft  <= 1'b0;
      o_stepright <= 1'b0;
      o_stepjump  <= 1'b0;
    end else begin
      o_stepleft  <= w_held_next[KEY_A] | w_held_next[KEY_LEFT];
      o_stepright <= w_held_next[KEY_D] | w_held_next[KEY_RIGHT];
      o_stepjump  <= w_held_next[KEY_W] | w_held_next[KEY_SPACE] | w_held_next[KEY_UP];
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Drives PS/2 frames into ps2_key_decoder. Expected output events
// ({left,right,jump} changes and frame_err pulses) are queued when stimulus
// is issued; a monitor pops and compares whenever the DUT shows an event.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int H = 20;  // PS/2 half bit period in system clocks

  logic clk;
  logic rst;
  logic i_ps2_clk;
  logic i_ps2_data;
  logic o_stepleft;
  logic o_stepright;
  logic o_stepjump;
  logic o_frame_err;

  typedef struct packed {
    logic       is_err;
    logic [2:0] val;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  bit   done;

  ps2_key_decoder #(
    .CLK_HZ    (65_000_000),
    .TIMEOUT_US(20),
    .FILTER_LEN(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .o_stepleft (o_stepleft),
    .o_stepright(o_stepright),
    .o_stepjump (o_stepjump),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input logic [2:0] v);
    q.push_back({1'b0, v});
  endtask

  task automatic expect_err();
    q.push_back({1'b1, 3'b000});
  endtask

  task automatic check_event(input logic is_err, input logic [2:0] val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: got err=%0b lrj=%03b, expected no event", is_err, val);
    end else begin
      e = q.pop_front();
      if (e.is_err !== is_err || (!is_err && e.val !== val)) begin
        errors++;
        $display("FAIL event: got err=%0b lrj=%03b, expected err=%0b lrj=%03b",
                 is_err, val, e.is_err, e.val);
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] v);
    checks++;
    if ({o_stepleft, o_stepright, o_stepjump} !== v) begin
      errors++;
      $display("FAIL %s: lrj=%03b, expected %03b", name,
               {o_stepleft, o_stepright, o_stepjump}, v);
    end
  endtask

  // Send the first nbits bits of a frame; optional 2-cycle clock glitches
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input bit glitch);
    logic [10:0] frame;
    logic        par;
    par   = bad_par ? (^b) : ~(^b);
    frame = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      i_ps2_data = frame[i];
      if (glitch) begin
        repeat (H / 2) @(posedge clk);
        i_ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        i_ps2_clk = 1'b1;
        repeat (H / 2) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
      i_ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      i_ps2_clk = 1'b1;
    end
    if (nbits == 11) begin
      i_ps2_data = 1'b1;
      repeat (60) @(posedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  // Monitor: compare every output change or frame_err pulse against the queue
  initial begin
    logic [2:0] prev;
    logic [2:0] cur;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      cur = {o_stepleft, o_stepright, o_stepjump};
      if (!rst && !done) begin
        if (o_frame_err) check_event(1'b1, 3'b000);
        if (cur != prev) check_event(1'b0, cur);
      end
      prev = cur;
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    done       = 1'b0;
    rst        = 1'b1;
    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outs("reset_outs", 3'b000);
    checks++;
    if (o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: frame_err=%0b, expected 0", o_frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // 1: A press and release
    expect_out(3'b100); send(8'h1C);
    send(8'hF0);
    expect_out(3'b000); send(8'h1C);
    check_drained("t1_a");

    // 2: Right arrow press/release; bare 74 and unmapped codes do nothing
    send(8'hE0); expect_out(3'b010); send(8'h74);
    send(8'hE0); send(8'hF0); expect_out(3'b000); send(8'h74);
    send(8'h74);
    send(8'hE1); send(8'h14);
    send(8'hF0); send(8'h23);
    check_drained("t2_right");
    check_outs("t2_bare74", 3'b000);

    // 3: A and Left overlap; releasing A keeps stepleft high
    expect_out(3'b100); send(8'h1C);
    send(8'hE0); send(8'h6B);
    send(8'hF0); send(8'h1C);
    check_outs("t3_pair_held", 3'b100);
    send(8'hE0); send(8'hF0); expect_out(3'b000); send(8'h6B);
    check_drained("t3_pair");

    // 4: Space with bad parity, then good
    expect_err(); send_frame(8'h29, 1'b1, 11, 1'b0);
    check_outs("t4_badpar", 3'b000);
    expect_out(3'b001); send(8'h29);
    send(8'hF0); expect_out(3'b000); send(8'h29);
    check_drained("t4_space");

    // 5: partial frame then stall past the timeout, then a good W
    expect_err(); send_frame(8'h1D, 1'b0, 7, 1'b0);
    repeat (1500) @(posedge clk);
    check_drained("t5_timeout");
    expect_out(3'b001); send(8'h1D);
    send(8'hF0); expect_out(3'b000); send(8'h1D);
    check_drained("t5_w");

    // 6: D with typematic repeats and clock glitches, then reset mid-frame
    expect_out(3'b010); send(8'h23);
    for (int k = 0; k < 10; k++) begin
      send_frame(8'h23, 1'b0, 11, 1'b1);
    end
    check_outs("t6_repeat", 3'b010);
    check_drained("t6_repeat_q");
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_outs("t6_rst_now", 3'b000);
    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    expect_out(3'b100); send(8'h1C);
    check_drained("t6_after_rst");

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
